sr_latency_probe: RTL and testbench

//  Initiator side of the latch shift-register delay line: drives the chain's serial input and watches its serial output.

---
 rtl/sr_probe_pkg.sv | 25 ++
 rtl/sr_probe_sync.sv | 20 ++
 rtl/sr_latency_probe.sv | 195 +++++++++++++++++++
 tb/tb_sr_latency_probe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_probe_pkg.sv
// Shared types and constants for the latch-chain latency probe.
package sr_probe_pkg;

   localparam int unsigned CNT_W_DEF = 10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FLUSH  = 3'd1,
      LAUNCH = 3'd2,
      PRBS   = 3'd3,
      DONE   = 3'd4
   } state_e;

   // PRBS7, x^7 + x^6 + 1; bit 0 holds the newest bit, bit 6 the oldest
   localparam logic [6:0] PRBS7_SEED = 7'h7F;

   function automatic logic prbs7_bit(input logic [6:0] s);
      return s[6] ^ s[5];
   endfunction

   function automatic logic [6:0] prbs7_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

endpackage

// File: rtl/sr_probe_sync.sv
// Multi-flop synchronizer for the asynchronous chain output.
module sr_probe_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sr_latency_probe.sv
// Flushes the latch chain, launches a 0->1 step and measures its latency.
// Optional PRBS7 bit-error check after detect: define SR_PROBE_PRBS_CHECK_EN.
module sr_latency_probe
   import sr_probe_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FLUSH_CYCLES = 300,
   parameter int unsigned MAX_CYCLES   = 1023,
   parameter int unsigned CNT_W        = CNT_W_DEF
`ifdef SR_PROBE_PRBS_CHECK_EN
  ,parameter int unsigned BIT_CYCLES   = 2,
   parameter int unsigned PRBS_BITS    = 255
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             sr_in_o,
   input  logic             sr_out_i,
   output logic             busy,
   output logic             done,
   output logic             stuck,
   output logic             timeout,
   output logic [CNT_W-1:0] latency,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned FL_W = $clog2(FLUSH_CYCLES);
   localparam int unsigned CW   = (FL_W > CNT_W) ? FL_W : CNT_W;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             sr_in_q, busy_q, done_q, stuck_q, timeout_q;
   logic [CNT_W-1:0] latency_q;
   logic [CNT_W-1:0] lat_c;
   logic             sr_out_sync;

   sr_probe_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (sr_out_i),
      .q_o   (sr_out_sync)
   );

   // Count includes the synchronizer delay; remove it, clamping at 0
   always_comb begin
      lat_c = '0;
      if (cnt_q >= CW'(SYNC_STAGES)) lat_c = CNT_W'(cnt_q - CW'(SYNC_STAGES));
   end

`ifdef SR_PROBE_PRBS_CHECK_EN
   localparam int unsigned PB_W = $clog2(PRBS_BITS + 1);
   localparam int unsigned PH_W = $clog2(BIT_CYCLES) + 1;
   localparam int unsigned RW   = CNT_W + 2;

   logic [6:0]       lfsr_q, rx_hist_q;
   logic [PB_W-1:0]  tx_cnt_q, rx_cnt_q;
   logic [PH_W-1:0]  tx_ph_q;
   logic [RW-1:0]    rxw_q;
   logic [CNT_W-1:0] err_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sr_in_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         stuck_q   <= 1'b0;
         timeout_q <= 1'b0;
         latency_q <= '0;
`ifdef SR_PROBE_PRBS_CHECK_EN
         lfsr_q    <= PRBS7_SEED;
         rx_hist_q <= '0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         tx_ph_q   <= '0;
         rxw_q     <= '0;
         err_cnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= FLUSH;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  stuck_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  latency_q <= '0;
`ifdef SR_PROBE_PRBS_CHECK_EN
                  err_cnt_q <= '0;
`endif
               end
            end
            FLUSH: begin
               if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                  cnt_q <= '0;
                  if (sr_out_sync) begin
                     stuck_q <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     sr_in_q <= 1'b1;
                     state_q <= LAUNCH;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            LAUNCH: begin
               if (sr_out_sync) begin
                  latency_q <= lat_c;
`ifdef SR_PROBE_PRBS_CHECK_EN
                  state_q   <= PRBS;
                  sr_in_q   <= prbs7_bit(PRBS7_SEED);
                  lfsr_q    <= prbs7_step(PRBS7_SEED);
                  tx_cnt_q  <= PB_W'(1);
                  tx_ph_q   <= '0;
                  rx_cnt_q  <= '0;
                  rx_hist_q <= '0;
                  rxw_q     <= RW'(lat_c) + RW'(SYNC_STAGES + BIT_CYCLES / 2);
`else
                  sr_in_q   <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
`endif
               end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
                  timeout_q <= 1'b1;
                  latency_q <= CNT_W'(MAX_CYCLES);
                  sr_in_q   <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`ifdef SR_PROBE_PRBS_CHECK_EN
            PRBS: begin
               // Transmit: one PRBS bit per BIT_CYCLES, then idle low
               if (tx_ph_q == PH_W'(BIT_CYCLES - 1)) begin
                  tx_ph_q <= '0;
                  if (tx_cnt_q != PB_W'(PRBS_BITS)) begin
                     sr_in_q  <= prbs7_bit(lfsr_q);
                     lfsr_q   <= prbs7_step(lfsr_q);
                     tx_cnt_q <= tx_cnt_q + PB_W'(1);
                  end else begin
                     sr_in_q <= 1'b0;
                  end
               end else begin
                  tx_ph_q <= tx_ph_q + PH_W'(1);
               end
               // Receive: self-synchronising check once the history is seeded
               if (rxw_q == '0) begin
                  rxw_q     <= RW'(BIT_CYCLES - 1);
                  rx_hist_q <= {rx_hist_q[5:0], sr_out_sync};
                  rx_cnt_q  <= rx_cnt_q + PB_W'(1);
                  if (rx_cnt_q >= PB_W'(7) && sr_out_sync != prbs7_bit(rx_hist_q) &&
                      err_cnt_q != '1)
                     err_cnt_q <= err_cnt_q + CNT_W'(1);
                  if (rx_cnt_q == PB_W'(PRBS_BITS - 1)) begin
                     sr_in_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end else begin
                  rxw_q <= rxw_q - RW'(1);
               end
            end
`endif
            DONE: begin
               sr_in_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sr_in_o = sr_in_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign stuck   = stuck_q;
   assign timeout = timeout_q;
   assign latency = latency_q;
`ifdef SR_PROBE_PRBS_CHECK_EN
   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_latency_probe.sv
// Bench for sr_latency_probe: delay-line model with force/flip and timing reference.
module tb_sr_latency_probe;

   localparam int FLUSH = 300;
   localparam int MAXC  = 1023;
   localparam int SYNC  = 2;
   localparam int BITC  = 2;
   localparam int NBITS = 255;
   localparam int HN    = 2048;

   logic       clk, rst_n, start, sr_out_i;
   logic       sr_in_o, busy, done, stuck, timeout;
   logic [9:0] latency, err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // delay-line model state
   int dly        = 37;
   int force_mode = 0;   // 0 none, 1 output stuck at 1, 2 output stuck at 0
   int cyc        = 0;
   bit flip_en    = 1'b0;
   int flip_base  = 0;
   int flip_j [3];
   bit hist [HN];

   sr_latency_probe dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sr_in_o  (sr_in_o),
      .sr_out_i (sr_out_i),
      .busy     (busy),
      .done     (done),
      .stuck    (stuck),
      .timeout  (timeout),
      .latency  (latency),
      .err_cnt  (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Chain model: output in cycle c equals input of cycle c-dly
   initial begin
      bit o;
      sr_out_i = 1'b0;
      forever begin
         @(negedge clk);
         hist[cyc % HN] = sr_in_o;
         o = (cyc >= dly) ? hist[(cyc - dly) % HN] : 1'b0;
         if (flip_en)
            for (int k = 0; k < 3; k++)
               if (cyc == flip_base + BITC * flip_j[k] || cyc == flip_base + BITC * flip_j[k] + 1)
                  o = ~o;
         if (force_mode == 1) o = 1'b1;
         if (force_mode == 2) o = 1'b0;
         sr_out_i = o;
         cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input int d, input int mode, input bit do_flip,
                      input int exp_err);
      int s, off, exp_done, done_cyc, ones, p0;
      int exp_lat;
      bit exp_stuck, exp_to;
      dly        = d;
      force_mode = mode;
      flip_en    = 1'b0;
      tick();
      start = 1'b1;
      s = cyc;
      check({tag, "_busy_idle"}, 32'(busy), 0);
      tick();
      start = 1'b0;
      check({tag, "_busy_run"}, 32'(busy), 1);
      check({tag, "_clr_stuck"}, 32'(stuck), 0);
      check({tag, "_clr_to"}, 32'(timeout), 0);
      check({tag, "_clr_lat"}, 32'(latency), 0);

      exp_stuck = 1'b0;
      exp_to    = 1'b0;
      if (mode == 1) begin
         exp_stuck = 1'b1;
         exp_lat   = 0;
         exp_done  = s + FLUSH + 1;
      end else if (mode == 2) begin
         exp_to    = 1'b1;
         exp_lat   = MAXC;
         exp_done  = s + FLUSH + 1 + MAXC;
      end else begin
         exp_lat   = d;
         p0        = s + FLUSH + d + SYNC + 2;
         exp_done  = p0;
`ifdef SR_PROBE_PRBS_CHECK_EN
         exp_done  = p0 + d + SYNC + BITC / 2 + BITC * (NBITS - 1) + 1;
`endif
      end
      if (do_flip) begin
         flip_base = s + FLUSH + 2 * d + SYNC + 2;
         flip_j[0] = 10 + int'($urandom_range(30, 0));
         flip_j[1] = flip_j[0] + 20 + int'($urandom_range(30, 0));
         flip_j[2] = flip_j[1] + 20 + int'($urandom_range(30, 0));
         flip_en   = 1'b1;
      end

      off      = int'($urandom_range(exp_done - s - 2, 2));
      done_cyc = -1;
      ones     = 0;
      for (int i = 0; i < exp_done - s + 20 && done_cyc < 0; i++) begin
         if (done === 1'b1) done_cyc = cyc;
         else begin
            if (sr_in_o === 1'b1) ones++;
            start = (cyc - s == off);
            tick();
         end
      end
      if (done_cyc < 0) check({tag, "_done_seen"}, 0, 1);
      else              check({tag, "_done_cyc"}, 32'(done_cyc - s), 32'(exp_done - s));
      check({tag, "_stuck"}, 32'(stuck), 32'(exp_stuck));
      check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
      check({tag, "_latency"}, 32'(latency), 32'(exp_lat));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
      if (mode == 1) check({tag, "_sr_in_ones"}, 32'(ones), 0);

      // start coinciding with done must be dropped
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_busy_after"}, 32'(busy), 0);
      tick();
      check({tag, "_busy_after2"}, 32'(busy), 0);
      check({tag, "_lat_hold"}, 32'(latency), 32'(exp_lat));
      force_mode = 0;
      flip_en    = 1'b0;
   endtask

   initial begin
      int s, dn;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (4) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sr_in", 32'(sr_in_o), 0);
      check("rst_stuck", 32'(stuck), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_latency", 32'(latency), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      rst_n = 1'b1;
      tick();

      run("d37", 37, 0, 1'b0, 0);
      run("d128", 128, 0, 1'b0, 0);
      run("d1", 1, 0, 1'b0, 0);
      for (int r = 0; r < 4; r++)
         run($sformatf("rnd%0d", r), int'($urandom_range(140, 2)), 0, 1'b0, 0);
      run("stuck1", 50, 1, 1'b0, 0);
      run("after_stuck", 20, 0, 1'b0, 0);
      run("stuck0", 40, 2, 1'b0, 0);

      // reset five cycles into LAUNCH aborts with no done pulse
      dly = 60;
      tick();
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
      while (cyc < s + FLUSH + 6) tick();
      check("mid_sr_in_launch", 32'(sr_in_o), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_sr_in", 32'(sr_in_o), 0);
      check("mid_rst_done", 32'(done), 0);
      dn = 0;
      repeat (200) begin
         tick();
         if (done === 1'b1) dn++;
      end
      check("mid_rst_no_done", 32'(dn), 0);
      run("post_rst", 37, 0, 1'b0, 0);

`ifdef SR_PROBE_PRBS_CHECK_EN
      run("prbs_flip", 37, 0, 1'b1, 9);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
